fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  PC generator + IF/ID output register for the single-cycle RISC core. Drives the
//  word-indexed instruction memory address (combinational read, RD = Mem[Addr[31:2]]),
//  captures the returned word with its PC and hands both downstream over a valid/ready
//  handshake. Handles redirects (branch/jump), stalls, and halt.
// PARAMETERS
//  RESET_VEC  32'h0000_0000  PC loaded on reset
//  XLEN       32             address/instruction width (only 32 supported)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   async active-low reset
//  imem_addr_o    out  32  instruction memory address (= pc)
//  imem_rdata_i   in   32  instruction memory read data (same cycle)
//  redirect_i     in   1   load redirect_pc_i, flush output slot
//  redirect_pc_i  in   32  redirect target
//  halt_i         in   1   stop fetching (level, sampled each clk)
//  out_valid_o    out  1   instr_o/pc_o hold a valid instruction
//  out_ready_i    in   1   downstream accepts when out_valid_o & out_ready_i
//  instr_o        out  32  fetched instruction
//  pc_o           out  32  PC of instr_o
//  halted_o       out  1   state == HALT
//  trap_o         out  1   misaligned-redirect pulse (FETCH_MISALIGN_TRAP_EN only)
// BEHAVIOUR
//  - Reset (rst=0, any time, async): pc=RESET_VEC, state=IDLE, out_valid_o=0,
//    instr_o=0, pc_o=0, halted_o=0, trap_o=0. Mid-operation reset drops in-flight instr.
//  - imem_addr_o = pc, combinational from pc register.
//  - States: IDLE -> RUN unconditionally on first clk after reset release (one bubble;
//    imem output is forced 0 while in reset). RUN -> HALT when halt_i=1 and no redirect.
//    HALT -> RUN only on redirect_i. IDLE/HALT do not fetch.
//  - Slot free = ~out_valid_o | out_ready_i.
//  - RUN priority per cycle: (1) redirect_i: pc<=redirect_pc_i, out_valid_o<=0 (flush,
//    even if out_ready_i=1 -- the slot is NOT refilled this cycle); (2) halt_i: go HALT,
//    pc held, out_valid_o<=out_valid_o & ~out_ready_i; (3) slot free: instr_o<=imem_rdata_i,
//    pc_o<=pc, out_valid_o<=1, pc<=pc+4; (4) else hold everything (stall).
//  - Latency: word at pc appears on instr_o 1 cycle after pc drives imem_addr_o;
//    back-to-back throughput 1 instr/cycle while out_ready_i=1.
//  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
//  - Redirect in HALT: pc<=target, state->RUN, first valid output next+1 cycle.
//  - instr_o/pc_o hold their value while out_valid_o=0 (not cleared on flush).
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc_i[1:0]!=2'b00 is not
//    loaded; trap_o=1 for exactly one cycle, pc_o<=bad target, out_valid_o<=0,
//    state->HALT. Applies in RUN and HALT.
//  Not defined: redirect_pc_i[1:0] are ignored (pc<={redirect_pc_i[31:2],2'b00});
//    trap_o tied 0.
// STRUCTURE
//  Package fetch_pkg: state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2), RESET_VEC
//    default, PC_INC=32'd4.
//  Sub-module fetch_next_pc: combinational next-pc select (redirect/alignment/inc/hold)
//    and misalign detect; fetch_unit keeps state FSM and output register.
// TESTING
//  1 Reset release, memfile words 0x00500293,0x00F28313, ready=1 -> cycle1 no valid;
//    then pc_o=0x0 instr 0x00500293, pc_o=0x4 instr 0x00F28313 on consecutive cycles.
//  2 Stall: ready=0 for 3 cycles with valid=1 -> instr_o/pc_o stable, imem_addr_o
//    frozen; ready=1 -> sequence resumes with no skip or duplicate.
//  3 Redirect to 0x40 while valid=1, ready=1 -> next cycle out_valid_o=0,
//    imem_addr_o=0x40; following cycle pc_o=0x40 valid.
//  4 halt_i=1 one cycle -> halted_o=1, no new fetches; redirect to 0x10 -> RUN,
//    pc_o=0x10 delivered two cycles later.
//  5 Redirect 0x22: with FETCH_MISALIGN_TRAP_EN -> trap_o 1-cycle pulse, pc_o=0x22,
//    halted_o=1; without -> fetch from 0x20, trap_o=0.
//  6 Assert rst mid-stream with valid=1 -> out_valid_o=0, pc=RESET_VEC immediately
//    (before next clk); pc at 0xFFFF_FFFC, ready=1 -> next pc 0x0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch slice: FSM state encoding,
// default reset vector and PC increment, plus a word-align helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;

    // Drop the byte offset so the PC always names a full instruction word.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch bus: instruction-memory address/data plus the valid/ready output
// slot towards decode. The fetch unit is the master side.
interface fetch_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_rdata_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] pc_o;

    modport master (
        output imem_addr_o,
        input  imem_rdata_i,
        output out_valid_o,
        input  out_ready_i,
        output instr_o,
        output pc_o
    );

    modport slave (
        input  imem_addr_o,
        output imem_rdata_i,
        input  out_valid_o,
        output out_ready_i,
        input  instr_o,
        input  pc_o
    );
endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC select: redirect target (word aligned), pc+4, or hold.
// With FETCH_MISALIGN_TRAP_EN defined a misaligned redirect is flagged and
// the PC holds instead of loading the target; otherwise the low bits of the
// target are dropped and misalign is tied low.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign = redirect & (redirect_pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Redirect beats advance; a trapped redirect leaves the PC where it is.
    always_comb begin
        next_pc = pc;
        if (redirect) begin
            if (!misalign)
                next_pc = align_word(redirect_pc);
        end else if (advance) begin
            next_pc = pc + PC_INC;   // wraps modulo 2^32
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC generator and IF/ID output register. Drives imem_addr_o from the PC,
// captures the same-cycle read data with its PC into a single valid/ready
// output slot, and handles redirect, stall and halt.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps
// into HALT and pulses trap_o instead of being silently aligned).
// Only XLEN = 32 is supported.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter int          XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,          // async, active low
    fetch_if.master         bus,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic            halted_o,
    output logic            trap_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, pco_q;

    logic            take_redirect;
    logic            load_slot;
    logic            trap_load;
    logic            misalign;
    logic            slot_free;

    assign slot_free = ~valid_q | bus.out_ready_i;

    fetch_next_pc #(.XLEN(XLEN)) u_next_pc (
        .pc          (pc_q),
        .redirect    (take_redirect),
        .redirect_pc (redirect_pc_i),
        .advance     (load_slot),
        .next_pc     (pc_d),
        .misalign    (misalign)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state and slot control. IDLE gives one bubble after reset;
    // redirect outranks halt, halt outranks a new fetch.
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        take_redirect = 1'b0;
        load_slot     = 1'b0;
        trap_load     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    take_redirect = 1'b1;
                    valid_d       = 1'b0;   // flush, no refill this cycle
                    if (misalign) begin
                        trap_load = 1'b1;
                        state_d   = HALT;
                    end
                end else if (halt_i) begin
                    state_d = HALT;
                    valid_d = valid_q & ~bus.out_ready_i;
                end else if (slot_free) begin
                    load_slot = 1'b1;
                    valid_d   = 1'b1;
                end
            end
            HALT: begin
                if (redirect_i) begin
                    take_redirect = 1'b1;
                    valid_d       = 1'b0;
                    if (misalign) trap_load = 1'b1;
                    else          state_d   = RUN;
                end else begin
                    // No fetch, but let a pending word drain downstream.
                    valid_d = valid_q & ~bus.out_ready_i;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // PC and output slot; instr/pc_o keep their value when the slot is flushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            instr_q <= '0;
            pco_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            if (load_slot) begin
                instr_q <= bus.imem_rdata_i;
                pco_q   <= pc_q;
            end else if (trap_load) begin
                pco_q   <= redirect_pc_i;   // report the faulting target
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q;

    // One-cycle pulse for each rejected misaligned redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) trap_q <= 1'b0;
        else      trap_q <= trap_load;
    end

    assign trap_o = trap_q;
`else
    assign trap_o = 1'b0;
`endif

    assign bus.imem_addr_o = pc_q;
    assign bus.out_valid_o = valid_q;
    assign bus.instr_o     = instr_q;
    assign bus.pc_o        = pco_q;
    assign halted_o        = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard queue of expected
// {pc, instr} pairs is filled as stimulus is driven and drained by a monitor
// on every accepted transfer; directed checks cover reset, stall, redirect,
// halt, misaligned redirect and PC wrap.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic        halted_o;
    logic        trap_o;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    fetch_if bus ();

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.master),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .halted_o      (halted_o),
        .trap_o        (trap_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory image: two known words at 0 and 4, a distinct address-derived
    // pattern everywhere else.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0293;
            32'h0000_0004: return 32'h00F2_8313;
            default:       return {a[31:2], 2'b00} ^ 32'h5A5A_0013;
        endcase
    endfunction

    assign bus.imem_rdata_i = rst ? imem_word(bus.imem_addr_o) : 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = imem_word(pc);
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every valid&ready cycle is a transfer at the coming edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.out_valid_o && bus.out_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", bus.pc_o, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", bus.pc_o, e.pc);
                chk("sb_instr", bus.instr_o, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b0;
        redirect_i      = 1'b0;
        redirect_pc_i   = 32'h0;
        halt_i          = 1'b0;
        bus.out_ready_i = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_valid", 32'(bus.out_valid_o), 32'h0);
        chk("rst_addr", bus.imem_addr_o, RESET_VEC_DEF);
        chk("rst_pc_o", bus.pc_o, 32'h0);
        chk("rst_instr", bus.instr_o, 32'h0);
        chk("rst_halted", 32'(halted_o), 32'h0);
        chk("rst_trap", 32'(trap_o), 32'h0);

        // 1: release, one bubble, then back-to-back words
        rst             = 1'b1;
        bus.out_ready_i = 1'b1;
        push(32'h0); push(32'h4); push(32'h8);
        step();
        chk("t1_bubble", 32'(bus.out_valid_o), 32'h0);
        step();
        chk("t1_valid", 32'(bus.out_valid_o), 32'h1);
        chk("t1_pc0", bus.pc_o, 32'h0);
        chk("t1_instr0", bus.instr_o, 32'h0050_0293);
        step();
        chk("t1_pc1", bus.pc_o, 32'h4);
        chk("t1_instr1", bus.instr_o, 32'h00F2_8313);
        step();

        // 2: stall three cycles holding word 8
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_valid", 32'(bus.out_valid_o), 32'h1);
            chk("t2_pc_o", bus.pc_o, 32'h8);
            chk("t2_instr", bus.instr_o, imem_word(32'h8));
            chk("t2_addr", bus.imem_addr_o, 32'hC);
        end
        bus.out_ready_i = 1'b1;
        push(32'hC); push(32'h10);
        step();
        step();

        // 3: redirect to 0x40 with the slot full and ready high
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        step();
        redirect_i = 1'b0;
        chk("t3_flush", 32'(bus.out_valid_o), 32'h0);
        chk("t3_addr", bus.imem_addr_o, 32'h40);
        push(32'h40);
        step();
        chk("t3_valid", 32'(bus.out_valid_o), 32'h1);
        chk("t3_pc_o", bus.pc_o, 32'h40);

        // 4: halt one cycle, drain, then redirect out of HALT
        bus.out_ready_i = 1'b0;
        halt_i          = 1'b1;
        step();
        halt_i = 1'b0;
        chk("t4_halted", 32'(halted_o), 32'h1);
        chk("t4_hold_valid", 32'(bus.out_valid_o), 32'h1);
        bus.out_ready_i = 1'b1;
        step();
        chk("t4_drained", 32'(bus.out_valid_o), 32'h0);
        chk("t4_no_fetch", bus.imem_addr_o, 32'h44);
        chk("t4_still_halted", 32'(halted_o), 32'h1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h10;
        step();
        redirect_i = 1'b0;
        chk("t4_run", 32'(halted_o), 32'h0);
        chk("t4_no_valid", 32'(bus.out_valid_o), 32'h0);
        push(32'h10);
        step();
        chk("t4_valid", 32'(bus.out_valid_o), 32'h1);
        chk("t4_pc_o", bus.pc_o, 32'h10);

        // 5: misaligned redirect to 0x22
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h22;
        step();
        redirect_i      = 1'b0;
        bus.out_ready_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t5_trap", 32'(trap_o), 32'h1);
        chk("t5_pc_o", bus.pc_o, 32'h22);
        chk("t5_halted", 32'(halted_o), 32'h1);
        chk("t5_valid", 32'(bus.out_valid_o), 32'h0);
        step();
        chk("t5_trap_pulse", 32'(trap_o), 32'h0);
        chk("t5_pc_held", bus.imem_addr_o, 32'h10 + 32'h4);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h20;
        step();
        redirect_i = 1'b0;
`else
        chk("t5_trap", 32'(trap_o), 32'h0);
        chk("t5_halted", 32'(halted_o), 32'h0);
`endif
        chk("t5_addr", bus.imem_addr_o, 32'h20);
        step();
        chk("t5_valid", 32'(bus.out_valid_o), 32'h1);
        chk("t5_fetch_pc", bus.pc_o, 32'h20);
        chk("t5_fetch_instr", bus.instr_o, imem_word(32'h20));

        // 6: asynchronous reset mid-stream, then PC wrap
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.out_valid_o), 32'h0);
        chk("t6_rst_addr", bus.imem_addr_o, RESET_VEC_DEF);
        chk("t6_rst_pc_o", bus.pc_o, 32'h0);
        step();
        rst = 1'b1;
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        chk("t6_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
        bus.out_ready_i = 1'b1;
        push(32'hFFFF_FFFC); push(32'h0);
        step();
        chk("t6_wrap_addr", bus.imem_addr_o, 32'h0);
        chk("t6_pc_top", bus.pc_o, 32'hFFFF_FFFC);
        step();
        chk("t6_pc_wrapped", bus.pc_o, 32'h0);
        step();
        bus.out_ready_i = 1'b0;
        step();

        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
